// File: rtl/vec_mem_sequencer_if.sv
// Request and RAM bus of the MEM-stage data-RAM sequencer.
// The slave side is the sequencer. The master side is the environment:
// the EX/MEM segment drives the request, and the RAM returns read data.
interface vec_mem_sequencer_if #(
  parameter int ADDR_W = 19,
  parameter int ELEM_W = 16,
  parameter int LANES  = 16
);
  // Request side (EX/MEM segment)
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_write;
  logic                    req_vector;
  logic [ADDR_W-1:0]       req_addr;
  logic [4:0]              req_rd;
  logic [LANES*ELEM_W-1:0] wdata_vec;
  logic [ELEM_W-1:0]       wdata_scalar;

  // Single-port RAM side
  logic [ADDR_W-1:0]       mem_addr;
  logic [ELEM_W-1:0]       mem_wdata;
  logic                    mem_wren;
  logic [ELEM_W-1:0]       mem_rdata;

  modport master (
    output req_valid, req_write, req_vector, req_addr, req_rd, wdata_vec, wdata_scalar,
    input  req_ready,
    input  mem_addr, mem_wdata, mem_wren,
    output mem_rdata
  );

  modport slave (
    input  req_valid, req_write, req_vector, req_addr, req_rd, wdata_vec, wdata_scalar,
    output req_ready,
    output mem_addr, mem_wdata, mem_wren,
    input  mem_rdata
  );
endinterface

// File: rtl/vec_mem_sequencer.sv
// MEM-stage sequencer for a single-port data RAM. Scalar accesses take one
// beat. Vector accesses are serialised into LANES beats. Read beats are
// gathered back into one vector. The pipeline is stalled while the RAM is busy.
module vec_mem_sequencer #(
  parameter int ADDR_W  = 19,
  parameter int ELEM_W  = 16,
  parameter int LANES   = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  vec_mem_sequencer_if.slave      bus,
  output logic                    stall,
  output logic                    done,
  output logic [LANES*ELEM_W-1:0] rdata_vec,
  output logic [4:0]              rd_out,
  output logic                    rd_vector,
  output logic [ADDR_W-1:0]       stall_cycles
);
  localparam int IDX_W = $clog2(LANES);
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        drain_q, drain_d;
  logic                    write_q, vector_q;
  logic [ADDR_W-1:0]       base_q;
  logic [4:0]              rd_q;
  logic [LANES*ELEM_W-1:0] wvec_q;
  logic [ELEM_W-1:0]       wscal_q;
  logic [LANES*ELEM_W-1:0] gather_q, gather_d;
  logic [LANES*ELEM_W-1:0] rdata_vec_q;
  logic [4:0]              rd_out_q;
  logic                    rd_vector_q;
  logic [ADDR_W-1:0]       stall_cnt_q;

  logic                    accept;
  logic                    last_beat;
  logic                    cap_vld;
  logic [IDX_W-1:0]        cap_lane;

  assign accept    = (state_q == S_IDLE) && bus.req_valid;
  assign last_beat = !vector_q || (idx_q == IDX_W'(LANES - 1));

  // Read-return pipeline: stage k holds the lane of the beat whose data
  // appears k+1 cycles after its address cycle.
  for (genvar gi = 0; gi < MEM_LAT; gi++) begin : g_pipe
    logic             vld_q;
    logic [IDX_W-1:0] lane_q;
    if (gi == 0) begin : g_head
      // Launch a tag for every read address cycle
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q  <= 1'b0;
          lane_q <= '0;
        end else begin
          vld_q  <= (state_q == S_READ);
          lane_q <= idx_q;
        end
      end
    end else begin : g_tail
      // Delay the tag by one more cycle of RAM latency
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld_q  <= 1'b0;
          lane_q <= '0;
        end else begin
          vld_q  <= g_pipe[gi-1].vld_q;
          lane_q <= g_pipe[gi-1].lane_q;
        end
      end
    end
  end

  assign cap_vld  = g_pipe[MEM_LAT-1].vld_q;
  assign cap_lane = g_pipe[MEM_LAT-1].lane_q;

  // Merge the returning read beat into the gather buffer
  always_comb begin
    gather_d = gather_q;
    if (cap_vld) gather_d[cap_lane*ELEM_W +: ELEM_W] = bus.mem_rdata;
  end

  // Next-state logic: beat sequencing and drain of outstanding reads
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          idx_d   = '0;
          drain_d = '0;
          state_d = bus.req_write ? S_WRITE : S_READ;
        end
      end
      S_WRITE: begin
        if (last_beat) state_d = S_DONE;
        else           idx_d   = idx_q + IDX_W'(1);
      end
      S_READ: begin
        if (last_beat) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == CNT_W'(MEM_LAT - 1)) state_d = S_DONE;
        else                                drain_d = drain_q + CNT_W'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, request latch, gather buffer and committed load result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      drain_q     <= '0;
      write_q     <= 1'b0;
      vector_q    <= 1'b0;
      base_q      <= '0;
      rd_q        <= '0;
      wvec_q      <= '0;
      wscal_q     <= '0;
      gather_q    <= '0;
      rdata_vec_q <= '0;
      rd_out_q    <= '0;
      rd_vector_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drain_q <= drain_d;
      if (accept) begin
        write_q  <= bus.req_write;
        vector_q <= bus.req_vector;
        base_q   <= bus.req_addr;
        rd_q     <= bus.req_rd;
        wvec_q   <= bus.wdata_vec;
        wscal_q  <= bus.wdata_scalar;
        gather_q <= '0;
      end else begin
        gather_q <= gather_d;
      end
      // Commit includes the final beat captured on this same edge
      if (state_q == S_DRAIN && state_d == S_DONE && !write_q) begin
        rdata_vec_q <= gather_d;
        rd_out_q    <= rd_q;
        rd_vector_q <= vector_q;
      end
    end
  end

  // Saturating count of stalled cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + ADDR_W'(1);
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.mem_addr  = base_q + ADDR_W'(idx_q);
  assign bus.mem_wren  = (state_q == S_WRITE);
  assign bus.mem_wdata = (state_q != S_WRITE) ? '0 :
                         vector_q ? wvec_q[idx_q*ELEM_W +: ELEM_W] : wscal_q;

  assign stall        = (state_q == S_WRITE) || (state_q == S_READ) || (state_q == S_DRAIN);
  assign done         = (state_q == S_DONE);
  assign rdata_vec    = rdata_vec_q;
  assign rd_out       = rd_out_q;
  assign rd_vector    = rd_vector_q;
  assign stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Directed bench for vec_mem_sequencer with a behavioural 1-cycle-latency RAM.
module tb_vec_mem_sequencer;
  localparam int ADDR_W = 19;
  localparam int ELEM_W = 16;
  localparam int LANES  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vec_mem_sequencer_if #(.ADDR_W(ADDR_W), .ELEM_W(ELEM_W), .LANES(LANES)) bus ();

  logic                    stall, done, rd_vector;
  logic [LANES*ELEM_W-1:0] rdata_vec;
  logic [4:0]              rd_out;
  logic [ADDR_W-1:0]       stall_cycles;

  vec_mem_sequencer #(.ADDR_W(ADDR_W), .ELEM_W(ELEM_W), .LANES(LANES), .MEM_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stall        (stall),
    .done         (done),
    .rdata_vec    (rdata_vec),
    .rd_out       (rd_out),
    .rd_vector    (rd_vector),
    .stall_cycles (stall_cycles)
  );

  // Behavioural RAM: synchronous write, registered read (latency 1)
  logic [ELEM_W-1:0] ram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] wr_addr [0:63];
  logic [ELEM_W-1:0] wr_data [0:63];
  int                wr_n;

  // Present a request on a negedge and let the next rising edge accept it
  task automatic start_req(input logic w, input logic v, input logic [ADDR_W-1:0] a,
                           input logic [4:0] rd, input logic [LANES*ELEM_W-1:0] wv,
                           input logic [ELEM_W-1:0] ws);
    bus.req_write    = w;
    bus.req_vector   = v;
    bus.req_addr     = a;
    bus.req_rd       = rd;
    bus.wdata_vec    = wv;
    bus.wdata_scalar = ws;
    bus.req_valid    = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  // Run to done; reports the done cycle relative to accept and stall count
  task automatic run_to_done(input string name, output int done_k, output int stall_n);
    done_k  = -1;
    stall_n = 0;
    wr_n    = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (bus.mem_wren && wr_n < 64) begin
        wr_addr[wr_n] = bus.mem_addr;
        wr_data[wr_n] = bus.mem_wdata;
        wr_n++;
      end
      if (stall) stall_n++;
      if (done) begin
        done_k = k;
        break;
      end
    end
    if (done_k < 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout: no done within 60 cycles", name);
    end
  endtask

  function automatic logic [LANES*ELEM_W-1:0] ramp(input int base);
    logic [LANES*ELEM_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i*ELEM_W +: ELEM_W] = ELEM_W'(base + i);
    return v;
  endfunction

  task automatic test_reset();
    int done_seen;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_vector = 1'b0;
    bus.req_addr = '0; bus.req_rd = '0; bus.wdata_vec = '0; bus.wdata_scalar = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", bus.req_ready); end
    checks++; if (stall !== 1'b0 || done !== 1'b0 || bus.mem_wren !== 1'b0) begin failures++;
      $display("FAIL rst_ctrl got stall=%b done=%b wren=%b exp=000", stall, done, bus.mem_wren); end
    checks++; if (stall_cycles !== '0 || rdata_vec !== '0 || rd_out !== 5'd0 || rd_vector !== 1'b0) begin failures++;
      $display("FAIL rst_outs got sc=%0h rd=%0d rv=%b exp zero", stall_cycles, rd_out, rd_vector); end
    rst = 1'b1;
    @(negedge clk);
    start_req(1'b1, 1'b1, 19'h00010, 5'd0, ramp(16'h3000), 16'h0);
    repeat (6) @(negedge clk);
    checks++; if (bus.mem_wren !== 1'b1 || bus.mem_addr !== 19'h00015) begin failures++;
      $display("FAIL rst_beat5 got wren=%b addr=%h exp wren=1 addr=00015", bus.mem_wren, bus.mem_addr); end
    #1 rst = 1'b0;
    #1;
    checks++; if (bus.mem_wren !== 1'b0) begin failures++; $display("FAIL rst_async_wren got=%b exp=0", bus.mem_wren); end
    checks++; if (bus.req_ready !== 1'b1 || stall !== 1'b0) begin failures++;
      $display("FAIL rst_async_idle got ready=%b stall=%b exp ready=1 stall=0", bus.req_ready, stall); end
    @(negedge clk);
    rst = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checks++; if (done_seen != 0 || bus.req_ready !== 1'b1) begin failures++;
      $display("FAIL rst_abandon got done_pulses=%0d ready=%b exp 0 and 1", done_seen, bus.req_ready); end
    $display("test_reset done");
  endtask

  task automatic test_vector_store();
    int dk, sn, bad;
    start_req(1'b1, 1'b1, 19'h00010, 5'd0, ramp(16'h1000), 16'h0);
    run_to_done("vst", dk, sn);
    checks++; if (dk != 17) begin failures++; $display("FAIL vst_done_cycle got=%0d exp=17", dk); end
    checks++; if (sn != 16) begin failures++; $display("FAIL vst_stall got=%0d exp=16", sn); end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (wr_n != 16 || wr_addr[i] !== ADDR_W'(19'h10 + i) || wr_data[i] !== ELEM_W'(16'h1000 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL vst_beats got beats=%0d bad=%0d exp 16 and 0", wr_n, bad); end
    bad = 0;
    for (int i = 0; i < 16; i++) if (ram[19'h10 + i] !== ELEM_W'(16'h1000 + i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL vst_ram got bad_words=%0d exp=0", bad); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || bus.req_ready !== 1'b1) begin failures++;
      $display("FAIL vst_after got done=%b ready=%b exp 0 and 1", done, bus.req_ready); end
    $display("test_vector_store done_cycle=%0d stall=%0d", dk, sn);
  endtask

  task automatic test_vector_load();
    int dk, sn;
    start_req(1'b0, 1'b1, 19'h00010, 5'd7, '0, 16'h0);
    run_to_done("vld", dk, sn);
    checks++; if (dk != 18) begin failures++; $display("FAIL vld_done_cycle got=%0d exp=18", dk); end
    checks++; if (sn != 17) begin failures++; $display("FAIL vld_stall got=%0d exp=17", sn); end
    checks++; if (rdata_vec !== ramp(16'h1000)) begin failures++; $display("FAIL vld_data got=%h exp=%h", rdata_vec, ramp(16'h1000)); end
    checks++; if (rd_out !== 5'd7 || rd_vector !== 1'b1) begin failures++;
      $display("FAIL vld_rd got rd=%0d vec=%b exp rd=7 vec=1", rd_out, rd_vector); end
    @(negedge clk);
    $display("test_vector_load done_cycle=%0d", dk);
  endtask

  task automatic test_scalar();
    int dk, sn;
    logic [LANES*ELEM_W-1:0] exp_v;
    start_req(1'b1, 1'b0, 19'h7FFFF, 5'd0, ramp(16'h5555), 16'hBEEF);
    run_to_done("sst", dk, sn);
    checks++; if (dk != 2 || sn != 1) begin failures++; $display("FAIL sst_timing got done=%0d stall=%0d exp 2 and 1", dk, sn); end
    checks++; if (wr_n != 1 || wr_data[0] !== 16'hBEEF || wr_addr[0] !== 19'h7FFFF) begin failures++;
      $display("FAIL sst_beat got n=%0d addr=%h data=%h exp 1 7ffff beef", wr_n, wr_addr[0], wr_data[0]); end
    checks++; if (rdata_vec !== ramp(16'h1000) || rd_out !== 5'd7 || rd_vector !== 1'b1) begin failures++;
      $display("FAIL sst_hold got rd=%0d vec=%b data=%h exp old load kept", rd_out, rd_vector, rdata_vec); end
    @(negedge clk);
    start_req(1'b0, 1'b0, 19'h7FFFF, 5'd12, '0, 16'h0);
    run_to_done("sld", dk, sn);
    exp_v = '0;
    exp_v[15:0] = 16'hBEEF;
    checks++; if (dk != 3) begin failures++; $display("FAIL sld_done_cycle got=%0d exp=3", dk); end
    checks++; if (rdata_vec !== exp_v) begin failures++; $display("FAIL sld_data got=%h exp=%h", rdata_vec, exp_v); end
    checks++; if (rd_out !== 5'd12 || rd_vector !== 1'b0) begin failures++;
      $display("FAIL sld_rd got rd=%0d vec=%b exp rd=12 vec=0", rd_out, rd_vector); end
    @(negedge clk);
    $display("test_scalar load_done_cycle=%0d", dk);
  endtask

  task automatic test_wrap();
    int dk, sn, bad;
    logic [ADDR_W-1:0] ea;
    start_req(1'b1, 1'b1, 19'h7FFF8, 5'd0, ramp(16'h2000), 16'h0);
    run_to_done("wrap", dk, sn);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      ea = (i < 8) ? ADDR_W'(19'h7FFF8 + i) : ADDR_W'(i - 8);
      if (wr_n != 16 || wr_addr[i] !== ea || ram[ea] !== ELEM_W'(16'h2000 + i)) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_addr got beats=%0d bad=%0d exp 16 and 0", wr_n, bad); end
    checks++; if (dk != 17) begin failures++; $display("FAIL wrap_done_cycle got=%0d exp=17", dk); end
    @(negedge clk);
    $display("test_wrap beats=%0d", wr_n);
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    d1 = -1; d2 = -1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++; if (stall_cycles !== '0) begin failures++; $display("FAIL b2b_clr got=%0d exp=0", stall_cycles); end
    bus.req_write = 1'b0; bus.req_vector = 1'b1; bus.req_addr = 19'h00010; bus.req_rd = 5'd3;
    bus.req_valid = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k == 1) begin bus.req_addr = 19'h7FFF8; bus.req_rd = 5'd9; end
      if (d1 > 0 && k == d1 + 1) begin
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_idle got=%b exp=1", bus.req_ready); end
      end
      if (d1 > 0 && k == d1 + 2) begin
        checks++; if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_accepted got ready=%b exp=0", bus.req_ready); end
        bus.req_valid = 1'b0;
      end
      if (done && d1 < 0) begin
        d1 = k;
        checks++; if (rdata_vec !== ramp(16'h1000) || rd_out !== 5'd3) begin failures++;
          $display("FAIL b2b_first got rd=%0d data=%h exp rd=3", rd_out, rdata_vec); end
      end else if (done) begin
        d2 = k;
        break;
      end
    end
    bus.req_valid = 1'b0;
    checks++; if (d1 != 18 || d2 != 37) begin failures++; $display("FAIL b2b_timing got d1=%0d d2=%0d exp 18 37", d1, d2); end
    checks++; if (rdata_vec !== ramp(16'h2000) || rd_out !== 5'd9 || rd_vector !== 1'b1) begin failures++;
      $display("FAIL b2b_second got rd=%0d vec=%b data=%h exp rd=9 vec=1", rd_out, rd_vector, rdata_vec); end
    checks++; if (stall_cycles !== 19'd34) begin failures++; $display("FAIL b2b_stall_cycles got=%0d exp=34", stall_cycles); end
    @(negedge clk);
    $display("test_back_to_back d1=%0d d2=%0d stall_cycles=%0d", d1, d2, stall_cycles);
  endtask

  initial begin
    test_reset();
    test_vector_store();
    test_vector_load();
    test_scalar();
    test_wrap();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
